instruction_fetcher: RTL and testbench



---
 rtl/instruction_fetcher.sv | 150 +++++++++++++++
 tb/tb_instruction_fetcher.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/instruction_fetcher.sv
// Instruction fetch stage: fetches current_pc over a valid/ready read channel and presents the word as FETCHED.
// Define INSTRUCTION_CACHE_EN to add a direct-mapped instruction cache in front of program memory.
module instruction_fetcher #(
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int PROGRAM_MEM_DATA_BITS = 16,
    parameter int CACHE_LINES           = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [2:0]                       core_state,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
    input  logic                             flush,
    output logic                             mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
    input  logic                             mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
    output logic [2:0]                       fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction
);

    localparam logic [2:0] CORE_FETCH  = 3'b001;
    localparam logic [2:0] CORE_DECODE = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE     = 3'b000,
        S_FETCHING = 3'b001,
        S_FETCHED  = 3'b010
    } state_t;

    state_t                             state_q;
    logic                               mem_read_valid_q;
    logic [PROGRAM_MEM_ADDR_BITS-1:0]   mem_read_address_q;
    logic [PROGRAM_MEM_DATA_BITS-1:0]   instruction_q;
    logic                               hit_s;
    logic [PROGRAM_MEM_DATA_BITS-1:0]   hit_data_s;

`ifdef INSTRUCTION_CACHE_EN
    localparam int IDX_BITS = $clog2(CACHE_LINES);

    logic [CACHE_LINES-1:0]             valid_q;
    logic [PROGRAM_MEM_DATA_BITS-1:0]   line_q [CACHE_LINES];
    logic [IDX_BITS-1:0]                lookup_idx_s;
    logic [IDX_BITS-1:0]                fill_idx_s;
    logic                               fill_s;
    logic                               tag_match_s;

    assign lookup_idx_s = current_pc[IDX_BITS-1:0];
    assign fill_idx_s   = mem_read_address_q[IDX_BITS-1:0];
    assign fill_s       = (state_q == S_FETCHING) && mem_read_ready;

    // A cache as large as the address space has no tag bits; every valid line matches.
    if (IDX_BITS < PROGRAM_MEM_ADDR_BITS) begin : g_tag
        localparam int TAG_W = PROGRAM_MEM_ADDR_BITS - IDX_BITS;
        logic [TAG_W-1:0] tag_q [CACHE_LINES];

        assign tag_match_s = (tag_q[lookup_idx_s] == current_pc[PROGRAM_MEM_ADDR_BITS-1:IDX_BITS]);

        // Tag storage written on fill from the latched request address.
        always_ff @(posedge clk) begin
            if (fill_s) begin
                tag_q[fill_idx_s] <= mem_read_address_q[PROGRAM_MEM_ADDR_BITS-1:IDX_BITS];
            end
        end
    end else begin : g_notag
        assign tag_match_s = 1'b1;
    end

    // Lookup reads the pre-flush valid bits, so a flush in the lookup cycle still allows a hit.
    always_comb begin
        hit_s      = 1'b0;
        hit_data_s = line_q[lookup_idx_s];
        if (valid_q[lookup_idx_s] && tag_match_s) begin
            hit_s = 1'b1;
        end else begin
            hit_s = 1'b0;
        end
    end

    // Valid bits: flush takes priority over a same-cycle fill.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= {CACHE_LINES{1'b0}};
        end else if (flush) begin
            valid_q <= {CACHE_LINES{1'b0}};
        end else if (fill_s) begin
            valid_q[fill_idx_s] <= 1'b1;
        end
    end

    // Line data written on fill.
    always_ff @(posedge clk) begin
        if (fill_s) begin
            line_q[fill_idx_s] <= mem_read_data;
        end
    end
`else
    logic unused_flush_s;

    assign hit_s          = 1'b0;
    assign hit_data_s     = {PROGRAM_MEM_DATA_BITS{1'b0}};
    assign unused_flush_s = flush;
`endif

    // Fetch FSM with registered memory request and instruction outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q            <= S_IDLE;
            mem_read_valid_q   <= 1'b0;
            mem_read_address_q <= {PROGRAM_MEM_ADDR_BITS{1'b0}};
            instruction_q      <= {PROGRAM_MEM_DATA_BITS{1'b0}};
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (core_state == CORE_FETCH) begin
                        if (hit_s) begin
                            instruction_q <= hit_data_s;
                            state_q       <= S_FETCHED;
                        end else begin
                            mem_read_valid_q   <= 1'b1;
                            mem_read_address_q <= current_pc;
                            state_q            <= S_FETCHING;
                        end
                    end
                end
                S_FETCHING: begin
                    if (mem_read_ready) begin
                        instruction_q    <= mem_read_data;
                        mem_read_valid_q <= 1'b0;
                        state_q          <= S_FETCHED;
                    end
                end
                S_FETCHED: begin
                    if (core_state == CORE_DECODE) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q          <= S_IDLE;
                    mem_read_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign fetcher_state    = state_q;
    assign mem_read_valid   = mem_read_valid_q;
    assign mem_read_address = mem_read_address_q;
    assign instruction      = instruction_q;

endmodule

// File: tb/tb_instruction_fetcher.sv
// Directed self-checking bench for instruction_fetcher; cache-dependent expectations follow INSTRUCTION_CACHE_EN.
module tb_instruction_fetcher;

    logic        clk;
    logic        reset;
    logic [2:0]  core_state;
    logic [7:0]  current_pc;
    logic        flush;
    logic        mem_read_valid;
    logic [7:0]  mem_read_address;
    logic        mem_read_ready;
    logic [15:0] mem_read_data;
    logic [2:0]  fetcher_state;
    logic [15:0] instruction;

    int checks = 0;
    int errors = 0;

    instruction_fetcher #(
        .PROGRAM_MEM_ADDR_BITS(8),
        .PROGRAM_MEM_DATA_BITS(16),
        .CACHE_LINES(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .core_state(core_state),
        .current_pc(current_pc),
        .flush(flush),
        .mem_read_valid(mem_read_valid),
        .mem_read_address(mem_read_address),
        .mem_read_ready(mem_read_ready),
        .mem_read_data(mem_read_data),
        .fetcher_state(fetcher_state),
        .instruction(instruction)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Miss: request held for lat cycles with a wandering PC, then response (optionally with flush).
    task automatic fetch_miss(input logic [7:0] pc, input logic [15:0] word, input int lat, input logic fl);
        @(negedge clk);
        core_state = 3'b001;
        current_pc = pc;
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            chk("miss_state", {29'd0, fetcher_state}, 32'd1);
            chk("miss_valid", {31'd0, mem_read_valid}, 32'd1);
            chk("miss_addr", {24'd0, mem_read_address}, {24'd0, pc});
            core_state = 3'b000;
            current_pc = pc ^ 8'hFF;
            if (i == lat - 1) begin
                mem_read_ready = 1'b1;
                mem_read_data  = word;
                flush          = fl;
            end
        end
        @(negedge clk);
        chk("miss_fetched", {29'd0, fetcher_state}, 32'd2);
        chk("miss_valid_low", {31'd0, mem_read_valid}, 32'd0);
        chk("miss_instr", {16'd0, instruction}, {16'd0, word});
        mem_read_ready = 1'b0;
        mem_read_data  = 16'hDEAD;
        flush          = 1'b0;
        core_state     = 3'b010;
        @(negedge clk);
        chk("miss_idle", {29'd0, fetcher_state}, 32'd0);
        chk("miss_instr_hold", {16'd0, instruction}, {16'd0, word});
        core_state = 3'b000;
    endtask

    // Refetch of a cached PC: a 1-cycle hit with the cache, a full miss without it.
    task automatic refetch(input logic [7:0] pc, input logic [15:0] word, input logic fl);
`ifdef INSTRUCTION_CACHE_EN
        @(negedge clk);
        core_state = 3'b001;
        current_pc = pc;
        flush      = fl;
        @(negedge clk);
        chk("hit_fetched", {29'd0, fetcher_state}, 32'd2);
        chk("hit_no_req", {31'd0, mem_read_valid}, 32'd0);
        chk("hit_instr", {16'd0, instruction}, {16'd0, word});
        flush      = 1'b0;
        core_state = 3'b010;
        @(negedge clk);
        chk("hit_idle", {29'd0, fetcher_state}, 32'd0);
        core_state = 3'b000;
`else
        fetch_miss(pc, word, 1, fl);
`endif
    endtask

    initial begin
        reset          = 1'b1;
        core_state     = 3'b000;
        current_pc     = 8'h00;
        flush          = 1'b0;
        mem_read_ready = 1'b1;
        mem_read_data  = 16'hFFFF;
        repeat (2) @(negedge clk);
        chk("rst_state", {29'd0, fetcher_state}, 32'd0);
        chk("rst_valid", {31'd0, mem_read_valid}, 32'd0);
        chk("rst_instr", {16'd0, instruction}, 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_hold_state", {29'd0, fetcher_state}, 32'd0);
        chk("idle_hold_valid", {31'd0, mem_read_valid}, 32'd0);
        chk("idle_hold_addr", {24'd0, mem_read_address}, 32'd0);
        core_state = 3'b010;
        @(negedge clk);
        chk("idle_decode_hold", {29'd0, fetcher_state}, 32'd0);
        core_state     = 3'b000;
        mem_read_ready = 1'b0;

        // Cold fetch and refetch
        fetch_miss(8'h05, 16'h3A7F, 3, 1'b0);
        refetch(8'h05, 16'h3A7F, 1'b0);

        // Aliasing on index 5
        fetch_miss(8'h0D, 16'h1234, 1, 1'b0);
        fetch_miss(8'h05, 16'h3A7F, 2, 1'b0);
        fetch_miss(8'h0D, 16'h1234, 1, 1'b0);

        // Flush coinciding with fill leaves the line invalid
        fetch_miss(8'h05, 16'h3A7F, 1, 1'b1);
        fetch_miss(8'h05, 16'h3A7F, 1, 1'b0);

        // Flush coinciding with lookup still hits, then the line is gone
        refetch(8'h05, 16'h3A7F, 1'b1);
        fetch_miss(8'h05, 16'h3A7F, 1, 1'b0);

        // Reset mid-fetch aborts the request and performs no fill
        @(negedge clk);
        core_state = 3'b001;
        current_pc = 8'h22;
        @(negedge clk);
        chk("abort_pre_valid", {31'd0, mem_read_valid}, 32'd1);
        core_state     = 3'b000;
        mem_read_ready = 1'b1;
        mem_read_data  = 16'h7777;
        reset          = 1'b1;
        #1;
        chk("abort_valid", {31'd0, mem_read_valid}, 32'd0);
        chk("abort_state", {29'd0, fetcher_state}, 32'd0);
        @(negedge clk);
        reset          = 1'b0;
        mem_read_ready = 1'b0;
        chk("abort_instr", {16'd0, instruction}, 32'd0);
        fetch_miss(8'h22, 16'h5555, 1, 1'b0);
        refetch(8'h22, 16'h5555, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
